// File: rtl/lbm_pkg.sv
// Shared LBM definitions: Q3.13 fixed-point type, D2Q9 weights, direction
// ordering and the node streamer FSM states.
package lbm_pkg;

    typedef logic signed [15:0] q3_13_t;

    localparam q3_13_t ONE_Q313 = 16'sh2000;
    localparam q3_13_t W_NULL   = 16'sh0e39;
    localparam q3_13_t W_SIDE   = 16'sh038e;
    localparam q3_13_t W_DIAG   = 16'sh00e4;

    typedef enum logic [3:0] {
        DIR_NULL = 4'd0,
        DIR_N    = 4'd1,
        DIR_NE   = 4'd2,
        DIR_E    = 4'd3,
        DIR_SE   = 4'd4,
        DIR_S    = 4'd5,
        DIR_SW   = 4'd6,
        DIR_W    = 4'd7,
        DIR_NW   = 4'd8
    } dir_e;

    localparam int unsigned NUM_DIRS    = 9;
    localparam int unsigned NUM_OUT_MAX = 12;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/node_out_serializer.sv
// Holds one node's collider results and plays them out as a registered
// valid/ready word stream, flagging the final word with m_last.
module node_out_serializer
    import lbm_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [NUM_OUT_MAX-1:0][15:0] words,
    input  logic                         m_ready,
    output logic                         m_valid,
    output logic [15:0]                  m_data,
    output logic                         m_last,
    output logic                         done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    logic [NUM_OUT_MAX-1:0][15:0] out_buf;
    logic [3:0]                   oidx;
    logic [3:0]                   next_idx;

    assign next_idx = oidx + 4'd1;
    assign done     = m_valid && m_ready && m_last;

    // m_data is preloaded from the buffer so the output stays registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_buf <= '0;
            oidx    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            out_buf <= words;
            oidx    <= '0;
            m_valid <= 1'b1;
            m_data  <= words[0];
            m_last  <= (LAST_IDX == 4'd0);
        end else if (m_valid && m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                oidx    <= '0;
            end else begin
                oidx    <= next_idx;
                m_data  <= out_buf[next_idx];
                m_last  <= (next_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: rtl/collider_node_streamer.sv
// Deserialises one D2Q9 node for the combinational collider, waits for its
// result and streams the post-collision populations back out.
module collider_node_streamer
    import lbm_pkg::*;
#(
    parameter int unsigned EMIT_MACRO = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       omega_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_data,
    output logic              m_last,
    output logic [15:0]       col_omega,
    output logic [15:0]       col_f_null,
    output logic [15:0]       col_f_n,
    output logic [15:0]       col_f_ne,
    output logic [15:0]       col_f_e,
    output logic [15:0]       col_f_se,
    output logic [15:0]       col_f_s,
    output logic [15:0]       col_f_sw,
    output logic [15:0]       col_f_w,
    output logic [15:0]       col_f_nw,
    input  logic [15:0]       col_f_new_null,
    input  logic [15:0]       col_f_new_n,
    input  logic [15:0]       col_f_new_ne,
    input  logic [15:0]       col_f_new_e,
    input  logic [15:0]       col_f_new_se,
    input  logic [15:0]       col_f_new_s,
    input  logic [15:0]       col_f_new_sw,
    input  logic [15:0]       col_f_new_w,
    input  logic [15:0]       col_f_new_nw,
    input  logic [15:0]       col_rho,
    input  logic [15:0]       col_u_x,
    input  logic [15:0]       col_u_y,
    input  logic              col_busy,
    input  logic              col_newval_ready,
    output logic              err_frame,
    output logic [CNT_W-1:0]  node_count
);

    localparam int unsigned NUM_WORDS = (EMIT_MACRO != 0) ? NUM_OUT_MAX : NUM_DIRS;
    localparam logic [3:0]  LAST_IN   = 4'(NUM_DIRS - 1);

    state_e                       state;
    state_e                       state_nx;
    logic [3:0]                   idx;
    logic [NUM_DIRS-1:0][15:0]    f_q;
    logic [NUM_OUT_MAX-1:0][15:0] out_words;
    logic                         accept;
    logic                         at_end;
    logic                         frame_err;
    logic                         node_in;
    logic                         capture;
    logic                         ser_done;

    assign accept    = s_valid && s_ready;
    assign at_end    = (idx == LAST_IN);
    assign frame_err = accept && (s_last != at_end);
    assign node_in   = accept && s_last && at_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: if (node_in)  state_nx = ISSUE;
            ISSUE:   if (capture)  state_nx = EMIT;
            EMIT:    if (ser_done) state_nx = COLLECT;
            default:               state_nx = COLLECT;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        capture = 1'b0;
        unique case (state)
            COLLECT: s_ready = rst_n;
            ISSUE:   capture = col_newval_ready && !col_busy;
            default: ;
        endcase
    end

    // A word carrying s_last always closes the frame, so a stray one is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            f_q        <= '0;
            col_omega  <= '0;
            err_frame  <= 1'b0;
            node_count <= '0;
        end else begin
            err_frame <= frame_err;
            if (accept) begin
                f_q[idx] <= s_data;
                if (idx == 4'd0) col_omega <= omega_in;
                if (s_last || at_end) idx <= '0;
                else                  idx <= idx + 4'd1;
            end
            if (ser_done) node_count <= node_count + 1'b1;
        end
    end

    assign col_f_null = f_q[DIR_NULL];
    assign col_f_n    = f_q[DIR_N];
    assign col_f_ne   = f_q[DIR_NE];
    assign col_f_e    = f_q[DIR_E];
    assign col_f_se   = f_q[DIR_SE];
    assign col_f_s    = f_q[DIR_S];
    assign col_f_sw   = f_q[DIR_SW];
    assign col_f_w    = f_q[DIR_W];
    assign col_f_nw   = f_q[DIR_NW];

    assign out_words[0]  = col_f_new_null;
    assign out_words[1]  = col_f_new_n;
    assign out_words[2]  = col_f_new_ne;
    assign out_words[3]  = col_f_new_e;
    assign out_words[4]  = col_f_new_se;
    assign out_words[5]  = col_f_new_s;
    assign out_words[6]  = col_f_new_sw;
    assign out_words[7]  = col_f_new_w;
    assign out_words[8]  = col_f_new_nw;
    assign out_words[9]  = col_rho;
    assign out_words[10] = col_u_x;
    assign out_words[11] = col_u_y;

    node_out_serializer #(
        .NUM_WORDS (NUM_WORDS)
    ) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (capture),
        .words   (out_words),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (ser_done)
    );

endmodule
